relogio_digital: RTL and testbench

- 24-hour digital clock (HH:MM:SS) for a 50 MHz FPGA board.
- Divides the system clock to a 1 Hz tick and counts BCD seconds, minutes and hours.
- Drives six active-low 7-segment digit outputs.
- Top-level display block; no upstream handshake.

---
 rtl/relogio_pkg.sv | 40 ++++
 rtl/relogio_digital_bcd_to_7seg.sv | 26 ++
 rtl/relogio_digital.sv | 96 +++++++++
 tb/tb_relogio_digital.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/relogio_pkg.sv
// rtl/relogio_pkg.sv - shared types, segment patterns and counting limits for relogio_digital
// Optional 12-hour mode selected by RELOGIO_12H_EN.
package relogio_pkg;

    typedef logic [3:0] bcd_t;

    // Active-low segments, bit order g,f,e,d,c,b,a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam bcd_t SEC_MAX_TENS = 4'd5;
    localparam bcd_t MIN_MAX_TENS = 4'd5;

`ifdef RELOGIO_12H_EN
    localparam int   HOUR_MAX        = 12;
    localparam bcd_t HOUR_RST_TENS   = 4'd1;
    localparam bcd_t HOUR_RST_UNITS  = 4'd2;
    localparam bcd_t HOUR_WRAP_TENS  = 4'd0;
    localparam bcd_t HOUR_WRAP_UNITS = 4'd1;
`else
    localparam int   HOUR_MAX        = 23;
    localparam bcd_t HOUR_RST_TENS   = 4'd0;
    localparam bcd_t HOUR_RST_UNITS  = 4'd0;
    localparam bcd_t HOUR_WRAP_TENS  = 4'd0;
    localparam bcd_t HOUR_WRAP_UNITS = 4'd0;
`endif

    localparam bcd_t HOUR_MAX_TENS  = bcd_t'(HOUR_MAX / 10);
    localparam bcd_t HOUR_MAX_UNITS = bcd_t'(HOUR_MAX % 10);

endpackage

// File: rtl/relogio_digital_bcd_to_7seg.sv
// rtl/relogio_digital_bcd_to_7seg.sv - combinational BCD to active-low 7-segment decoder
module bcd_to_7seg
    import relogio_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/relogio_digital.sv
// rtl/relogio_digital.sv - HH:MM:SS BCD clock with 1 Hz prescaler and six 7-segment outputs
// Define RELOGIO_12H_EN for 12-hour counting (12,01..11).
module relogio_digital
    import relogio_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    output logic [6:0] s_lsd,
    output logic [6:0] s_msd,
    output logic [6:0] m_lsd,
    output logic [6:0] m_msd,
    output logic [6:0] h_lsd,
    output logic [6:0] h_msd
);

    localparam int CW = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_FREQ_HZ / 2);

    logic [CW-1:0] prescaler;
    logic [CW-1:0] prescaler_next;
    logic          tick;
    logic          clk_1hz;
    logic          minuto_pulso;
    logic          hora_pulso;
    logic          hour_at_max;

    bcd_t segundos_unidade, segundos_dezena;
    bcd_t minutos_unidade,  minutos_dezena;
    bcd_t horas_unidade,    horas_dezena;

    // Pulses are gated by reset so they read zero while reset holds the counters
    always_comb begin
        tick           = !reset && (prescaler == LAST);
        prescaler_next = (prescaler == LAST) ? '0 : prescaler + CW'(1);
        minuto_pulso   = tick && (segundos_unidade == 4'd9) && (segundos_dezena == SEC_MAX_TENS);
        hora_pulso     = minuto_pulso && (minutos_unidade == 4'd9) && (minutos_dezena == MIN_MAX_TENS);
        hour_at_max    = (horas_dezena == HOUR_MAX_TENS) && (horas_unidade == HOUR_MAX_UNITS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler        <= '0;
            clk_1hz          <= 1'b0;
            segundos_unidade <= '0;
            segundos_dezena  <= '0;
            minutos_unidade  <= '0;
            minutos_dezena   <= '0;
            horas_unidade    <= HOUR_RST_UNITS;
            horas_dezena     <= HOUR_RST_TENS;
        end else begin
            prescaler <= prescaler_next;
            clk_1hz   <= (prescaler_next >= HALF);

            if (tick) begin
                if (segundos_unidade == 4'd9) begin
                    segundos_unidade <= '0;
                    segundos_dezena  <= (segundos_dezena == SEC_MAX_TENS) ? '0 : segundos_dezena + 4'd1;
                end else begin
                    segundos_unidade <= segundos_unidade + 4'd1;
                end
            end

            if (minuto_pulso) begin
                if (minutos_unidade == 4'd9) begin
                    minutos_unidade <= '0;
                    minutos_dezena  <= (minutos_dezena == MIN_MAX_TENS) ? '0 : minutos_dezena + 4'd1;
                end else begin
                    minutos_unidade <= minutos_unidade + 4'd1;
                end
            end

            if (hora_pulso) begin
                if (hour_at_max) begin
                    horas_dezena  <= HOUR_WRAP_TENS;
                    horas_unidade <= HOUR_WRAP_UNITS;
                end else if (horas_unidade == 4'd9) begin
                    horas_unidade <= '0;
                    horas_dezena  <= horas_dezena + 4'd1;
                end else begin
                    horas_unidade <= horas_unidade + 4'd1;
                end
            end
        end
    end

    bcd_to_7seg u_s_lsd (.bcd(segundos_unidade), .seg(s_lsd));
    bcd_to_7seg u_s_msd (.bcd(segundos_dezena),  .seg(s_msd));
    bcd_to_7seg u_m_lsd (.bcd(minutos_unidade),  .seg(m_lsd));
    bcd_to_7seg u_m_msd (.bcd(minutos_dezena),   .seg(m_msd));
    bcd_to_7seg u_h_lsd (.bcd(horas_unidade),    .seg(h_lsd));
    bcd_to_7seg u_h_msd (.bcd(horas_dezena),     .seg(h_msd));

endmodule

// File: tb/tb_relogio_digital.sv
// tb/tb_relogio_digital.sv - self-checking bench for relogio_digital against a seconds-of-day model
// Honours RELOGIO_12H_EN the same way as the design.
module tb_relogio_digital;

    localparam int N = 10;

`ifdef RELOGIO_12H_EN
    localparam logic [41:0] RST_DISP  = {7'b1111001, 7'b0100100, {4{7'b1000000}}};
    localparam logic [13:0] WRAP_HOUR = {7'b1111001, 7'b0100100};
`else
    localparam logic [41:0] RST_DISP  = {6{7'b1000000}};
    localparam logic [13:0] WRAP_HOUR = {7'b1000000, 7'b1000000};
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd;

    relogio_digital #(.CLK_FREQ_HZ(N)) dut (
        .clock(clock), .reset(reset),
        .s_lsd(s_lsd), .s_msd(s_msd), .m_lsd(m_lsd),
        .m_msd(m_msd), .h_lsd(h_lsd), .h_msd(h_msd)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: time of day as seconds since midnight plus a prescale phase
    int m_secs = 0;
    int m_p = 0;
    bit m_valid = 1'b0;
    int pre_val = 0;
    int pre_seq = 0;
    int seen_seq = 0;

    function automatic logic [6:0] seg(input int d);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    function automatic int disp_hour(input int s);
        int h;
        h = s / 3600;
`ifdef RELOGIO_12H_EN
        h = h % 12;
        if (h == 0) h = 12;
`endif
        return h;
    endfunction

    function automatic logic [41:0] exp_disp(input int s);
        int h, mi, se;
        h  = disp_hour(s);
        mi = (s / 60) % 60;
        se = s % 60;
        return {seg(h / 10), seg(h % 10), seg(mi / 10), seg(mi % 10), seg(se / 10), seg(se % 10)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clock) begin : model
        int cur;
        cur = m_secs;
        if (pre_seq != seen_seq) begin
            cur = pre_val;
            seen_seq <= pre_seq;
        end
        if (reset) begin
            m_p     <= 0;
            m_secs  <= 0;
            m_valid <= 1'b1;
        end else if (m_p == N - 1) begin
            m_p    <= 0;
            m_secs <= (cur + 1) % 86400;
        end else begin
            m_p    <= m_p + 1;
            m_secs <= cur;
        end
    end

    always @(negedge clock) begin : compare
        bit tk;
        if (m_valid) begin
            tk = !reset && (m_p == N - 1);
            chk("display", {22'd0, h_msd, h_lsd, m_msd, m_lsd, s_msd, s_lsd}, {22'd0, exp_disp(m_secs)});
            chk("clk_1hz", {63'd0, dut.clk_1hz}, {63'd0, (m_p >= N / 2)});
            chk("minuto_pulso", {63'd0, dut.minuto_pulso}, {63'd0, tk && (m_secs % 60 == 59)});
            chk("hora_pulso", {63'd0, dut.hora_pulso}, {63'd0, tk && (m_secs % 3600 == 3599)});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_reset(input logic v);
        #1 reset = v;
    endtask

    task automatic preload(input int s);
        int h, mi, se;
        h  = disp_hour(s);
        mi = (s / 60) % 60;
        se = s % 60;
        @(negedge clock);
        #2;
        force dut.horas_dezena     = 4'(h / 10);
        force dut.horas_unidade    = 4'(h % 10);
        force dut.minutos_dezena   = 4'(mi / 10);
        force dut.minutos_unidade  = 4'(mi % 10);
        force dut.segundos_dezena  = 4'(se / 10);
        force dut.segundos_unidade = 4'(se % 10);
        #1;
        release dut.horas_dezena;
        release dut.horas_unidade;
        release dut.minutos_dezena;
        release dut.minutos_unidade;
        release dut.segundos_dezena;
        release dut.segundos_unidade;
        pre_val = s;
        pre_seq++;
    endtask

    task automatic count_pulses(input int n, output int mc, output int hc, output int both);
        mc = 0; hc = 0; both = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (dut.minuto_pulso) mc++;
            if (dut.hora_pulso) hc++;
            if (dut.minuto_pulso && dut.hora_pulso) both++;
        end
    endtask

    initial begin : stim
        int mc, hc, both;
        reset = 1'b1;
        cyc(5);
        set_reset(1'b0);
        chk("reset_disp", {22'd0, h_msd, h_lsd, m_msd, m_lsd, s_msd, s_lsd}, {22'd0, RST_DISP});
        chk("reset_clk_1hz", {63'd0, dut.clk_1hz}, 64'd0);
        cyc(9);
        chk("s_lsd_before_first_tick", {57'd0, s_lsd}, {57'd0, 7'b1000000});
        cyc(1);
        chk("s_lsd_first_tick", {57'd0, s_lsd}, {57'd0, 7'b1111001});

        cyc(580);
        chk("sec_59", {50'd0, s_msd, s_lsd}, {50'd0, 7'b0010010, 7'b0010000});
        count_pulses(10, mc, hc, both);
        chk("minuto_pulso_width", 64'(mc), 64'd1);
        chk("disp_00_01_00", {22'd0, h_msd, h_lsd, m_msd, m_lsd, s_msd, s_lsd},
            {22'd0, RST_DISP[41:28], 7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000});

        preload(3595);
        count_pulses(70, mc, hc, both);
        chk("hour_roll_minuto", 64'(mc), 64'd1);
        chk("hour_roll_hora", 64'(hc), 64'd1);
        chk("hour_roll_hm", {36'd0, h_msd, h_lsd, m_msd, m_lsd}, {36'd0, 7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000});

        preload(86395);
        count_pulses(70, mc, hc, both);
        chk("day_wrap_both", 64'(both), 64'd1);
        chk("day_wrap_hm", {36'd0, h_msd, h_lsd, m_msd, m_lsd}, {36'd0, WRAP_HOUR, 7'b1000000, 7'b1000000});

`ifdef RELOGIO_12H_EN
        preload(43195);
        count_pulses(70, mc, hc, both);
        chk("noon_to_12", {50'd0, h_msd, h_lsd}, {50'd0, 7'b1111001, 7'b0100100});
`endif

        preload(45296);
        cyc(3 + $urandom_range(0, 4));
        set_reset(1'b1);
        cyc(1);
        set_reset(1'b0);
        chk("mid_reset_disp", {22'd0, h_msd, h_lsd, m_msd, m_lsd, s_msd, s_lsd}, {22'd0, RST_DISP});
        cyc(9);
        chk("mid_reset_no_early_tick", {57'd0, s_lsd}, {57'd0, 7'b1000000});
        cyc(1);
        chk("mid_reset_tick_at_10", {57'd0, s_lsd}, {57'd0, 7'b1111001});

        for (int k = 0; k < 6; k++) begin
            preload($urandom_range(0, 86399));
            cyc($urandom_range(5, 400));
            if ($urandom_range(0, 1) == 1) begin
                set_reset(1'b1);
                cyc($urandom_range(1, 3));
                set_reset(1'b0);
            end
            cyc($urandom_range(5, 200));
        end

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
